seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 167 ++++++++++++++++
 tb/tb_seq_divider.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, WIDTH cycles per result, 1-cycle done pulse.
// Optional signed mode enabled by defining SIGNED_DIV_EN (magnitude divide with sign fix-up on the last step).
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] acc;      // partial remainder
    logic [WIDTH-1:0] dvd;      // dividend bits shift out MSB-first, quotient bits shift in
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             last;
    logic             div_zero_in;

`ifdef SIGNED_DIV_EN
    logic neg_q;
    logic neg_r;
    logic a_neg;
    logic b_neg;

    always_comb begin
        a_neg = is_signed & dividend[WIDTH-1];
        b_neg = is_signed & divisor[WIDTH-1];
        a_mag = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag = b_neg ? (~divisor + 1'b1) : divisor;
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;

    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
    end
`endif

    assign div_zero_in = (divisor == '0);
    assign last        = (cnt == CW'(WIDTH - 1));

    // Trial subtraction is one bit wider so the borrow doubles as the quotient bit.
    always_comb begin
        shifted = {acc, dvd[WIDTH-1]};
        diff    = shifted - {1'b0, dsr};
        qbit    = ~diff[WIDTH];
        acc_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_nxt = {dvd[WIDTH-2:0], qbit};
`ifdef SIGNED_DIV_EN
        q_fin   = neg_q ? (~dvd_nxt + 1'b1) : dvd_nxt;
        r_fin   = neg_r ? (~acc_nxt + 1'b1) : acc_nxt;
`else
        q_fin   = dvd_nxt;
        r_fin   = acc_nxt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = div_zero_in ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (div_zero_in) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            acc         <= '0;
                            dvd         <= a_mag;
                            dsr         <= b_mag;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
                            neg_q       <= a_neg ^ b_neg;
                            neg_r       <= a_neg;
`endif
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    dvd <= dvd_nxt;
                    if (last) begin
                        cnt       <= '0;
                        quotient  <= q_fin;
                        remainder <= r_fin;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed + random bench for seq_divider; expectations come from a / and % arithmetic model.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         is_signed = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        dz = (b == 0);
        if (dz) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
`ifdef SIGNED_DIV_EN
            if (s) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    r = '0;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                end
            end
`else
            if (s) q = a / b;
`endif
        end
    endfunction

    // Drive a request; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Waits for done (bounded), checks latency/results, then steps to the first IDLE cycle.
    task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic s, input bit scramble);
        logic [W-1:0] eq, er, pq, pr;
        logic         edz;
        int           lat = 0;
        int           exp_lat;
        bit           busy_ok = 1'b1;
        bit           stable = 1'b1;
        model(a, b, s, eq, er, edz);
        exp_lat = edz ? 0 : W;
        pq = quotient;
        pr = remainder;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (quotient !== pq || remainder !== pr) stable = 1'b0;
            if (scramble) begin
                dividend = $urandom;
                divisor  = $urandom;
                start    = 1'b1;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (exp_lat > 0) begin
            chk({tag, "_busy_calc"}, 64'(busy_ok), 64'd1);
            chk({tag, "_hold_calc"}, 64'(stable), 64'd1);
        end
        chk({tag, "_quotient"}, 64'(quotient), 64'(eq));
        chk({tag, "_remainder"}, 64'(remainder), 64'(er));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edz));
        chk({tag, "_busy_done"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_q_held"}, 64'(quotient), 64'(eq));
    endtask

    initial begin
        logic [W-1:0] a, b;
        bit           saw_done;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(32'd100, 32'd7, 1'b0);
        chk("d100_busy_accept", 64'(busy), 64'd1);
        finish_op("d100", 32'd100, 32'd7, 1'b0, 1'b0);

        // Back-to-back: accepted on the first IDLE cycle.
        issue(32'h1234_5678, 32'd0, 1'b0);
        finish_op("dbz", 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        issue(32'd50, 32'd5, 1'b0);
        finish_op("after_dbz", 32'd50, 32'd5, 1'b0, 1'b0);

        // start held high with changing operands during CALC.
        dividend = 32'd1000;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        finish_op("hold", 32'd1000, 32'd7, 1'b0, 1'b1);
        dividend = 32'd1000;
        divisor  = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold_next_accept", 64'(busy), 64'd1);
        finish_op("hold_next", 32'd1000, 32'd10, 1'b0, 1'b0);

        issue(32'hFFFF_FFFF, 32'd1, 1'b0);
        finish_op("div_one", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        issue(32'd3, 32'd10, 1'b0);
        finish_op("small", 32'd3, 32'd10, 1'b0, 1'b0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        finish_op("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        finish_op("big_unsigned", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 32'd1;
            issue(a, b, 1'b0);
            finish_op($sformatf("rand%0d", i), a, b, 1'b0, 1'b0);
        end

`ifdef SIGNED_DIV_EN
        issue(-32'sd7, 32'd2, 1'b1);
        finish_op("s_m7_2", -32'sd7, 32'd2, 1'b1, 1'b0);
        issue(32'd7, -32'sd2, 1'b1);
        finish_op("s_7_m2", 32'd7, -32'sd2, 1'b1, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        finish_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(-32'sd9, -32'sd4, 1'b1);
        finish_op("s_m9_m4", -32'sd9, -32'sd4, 1'b1, 1'b0);
        issue(-32'sd5, 32'd0, 1'b1);
        finish_op("s_dbz", -32'sd5, 32'd0, 1'b1, 1'b0);
`endif

        // Reset in the middle of CALC aborts without a done pulse.
        issue(32'd100000, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_quotient", 64'(quotient), 64'd0);
        chk("abort_remainder", 64'(remainder), 64'd0);
        chk("abort_dbz", 64'(div_by_zero), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'd0);
        issue(32'd65535, 32'd255, 1'b0);
        finish_op("post_rst", 32'd65535, 32'd255, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
